// File: rtl/aq_djpeg_pixout_if.sv
// Pixel input stream and packed output word stream of aq_djpeg_pixout.
// master = pixel source / word sink, slave = aq_djpeg_pixout.
interface aq_djpeg_pixout_if #(
   parameter int OUT_W = 32
);
   logic             InEnable;
   logic [15:0]      InPixelX, InPixelY;
   logic [7:0]       InR, InG, InB;
   logic             InReady;
   logic             OutValid, OutReady;
   logic [OUT_W-1:0] OutData;
   logic             OutEol, OutLast;

   modport master (
      output InEnable, InPixelX, InPixelY, InR, InG, InB, OutReady,
      input  InReady, OutValid, OutData, OutEol, OutLast
   );
   modport slave (
      input  InEnable, InPixelX, InPixelY, InR, InG, InB, OutReady,
      output InReady, OutValid, OutData, OutEol, OutLast
   );
endinterface

// File: rtl/aq_djpeg_pixout.sv
// Packs colour-converted pixels into OUT_W-bit words, crops to the image size and queues words in a FIFO.
// Define AQ_DJPEG_PIXOUT_RGB565_EN to enable RGB565 packing; otherwise output is always RGB888.
module aq_djpeg_pixout #(
   parameter int FIFO_DEPTH = 16,
   parameter int OUT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ProcessInit,
   input  logic              Mode,
   input  logic [15:0]       InWidth,
   input  logic [15:0]       InHeight,
   aq_djpeg_pixout_if.slave  px,
   output logic              Overflow,
   output logic [15:0]       DropCount
);
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int EW     = OUT_W + 2;
   localparam int PPW888 = OUT_W / 32;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;

   logic [OUT_W-1:0] acc_q, acc_d, acc_ins, wd_q, wd_d;
   logic [1:0]       idx_q, idx_d;
   logic             wv_q, wv_d, weol_q, weol_d, wlast_q, wlast_d;
   logic [EW-1:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q, cnt_d;
   logic             rdy_q, rdy_d, ovf_q, ovf_d;
   logic [15:0]      drop_q, drop_d;
   logic             acc_en, in_bounds, row_end, frame_end, slot_last, push, pop, full;
   logic [31:0]      slot888;
   logic [EW-1:0]    head;

   assign acc_en    = (state_q == RUN) && px.InEnable;
   assign in_bounds = (px.InPixelX < InWidth) && (px.InPixelY < InHeight);
   assign row_end   = px.InPixelX == InWidth - 16'd1;
   assign frame_end = row_end && (px.InPixelY == InHeight - 16'd1);
   assign slot888   = {8'h00, px.InR, px.InG, px.InB};

`ifdef AQ_DJPEG_PIXOUT_RGB565_EN
   localparam int PPW565 = OUT_W / 16;
   logic        mode_q;
   logic [15:0] slot565;
   assign slot565 = {px.InR[7:3], px.InG[7:2], px.InB[7:3]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    mode_q <= 1'b0;
      else if (state_q == IDLE && state_d == RUN) mode_q <= Mode;
   end
`else
   logic unused_mode;
   assign unused_mode = Mode;
`endif

   // Drop the current pixel into slot idx_q of the accumulator.
   always_comb begin
      acc_ins   = acc_q;
      slot_last = 1'b0;
`ifdef AQ_DJPEG_PIXOUT_RGB565_EN
      if (mode_q) begin
         for (int s = 0; s < PPW565; s++)
            if (int'(idx_q) == s) acc_ins[s*16 +: 16] = slot565;
         slot_last = int'(idx_q) == PPW565 - 1;
      end else
`endif
      begin
         for (int s = 0; s < PPW888; s++)
            if (int'(idx_q) == s) acc_ins[s*32 +: 32] = slot888;
         slot_last = int'(idx_q) == PPW888 - 1;
      end
   end

   always_comb begin
      state_d = state_q;
      if (ProcessInit) state_d = IDLE;
      else begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (acc_en && in_bounds && frame_end) state_d = DONE;
            default: state_d = state_q;
         endcase
      end
   end

   assign pop  = (cnt_q != '0) && px.OutReady;
   assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
   assign push = wv_q && (!full || pop);

   always_comb begin
      acc_d   = acc_q;
      idx_d   = idx_q;
      wd_d    = wd_q;
      weol_d  = weol_q;
      wlast_d = wlast_q;
      wv_d    = 1'b0;
      drop_d  = drop_q;
      ovf_d   = ovf_q || (wv_q && full && !pop);
      cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (acc_en) begin
         if (!in_bounds) begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
         end else if (slot_last || row_end) begin
            wd_d    = acc_ins;
            weol_d  = row_end;
            wlast_d = frame_end;
            wv_d    = 1'b1;
            acc_d   = '0;
            idx_d   = '0;
         end else begin
            acc_d = acc_ins;
            idx_d = idx_q + 2'd1;
         end
      end
      // Ready reflects the FIFO after this cycle's push and pop.
      rdy_d = (state_d == RUN) && (int'(cnt_d) <= FIFO_DEPTH - 2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         idx_q   <= '0;
         wd_q    <= '0;
         weol_q  <= 1'b0;
         wlast_q <= 1'b0;
         wv_q    <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         weol_q  <= weol_d;
         wlast_q <= wlast_d;
         if (ProcessInit) begin
            acc_q  <= '0;
            idx_q  <= '0;
            wv_q   <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            rdy_q  <= 1'b0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
         end else begin
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            wv_q   <= wv_d;
            cnt_q  <= cnt_d;
            rdy_q  <= rdy_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !ProcessInit) mem_q[wr_q] <= {wlast_q, weol_q, wd_q};
   end

   // Outputs read zero whenever the FIFO is empty, so reset values need no RAM clear.
   assign head                                = (cnt_q != '0) ? mem_q[rd_q] : '0;
   assign {px.OutLast, px.OutEol, px.OutData} = head;
   assign px.OutValid                         = cnt_q != '0;
   assign px.InReady                          = rdy_q;
   assign Overflow                            = ovf_q;
   assign DropCount                           = drop_q;
endmodule

// File: tb/tb_aq_djpeg_pixout.sv
// Self-checking bench for aq_djpeg_pixout: directed vector table, corner sequences, randomized frames vs a packing model.
`timescale 1ns/1ps
module tb_aq_djpeg_pixout;
   localparam int OUT_W = 64;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, ProcessInit, Mode;
   logic [15:0] InWidth, InHeight;
   logic        Overflow;
   logic [15:0] DropCount;
   int          nvec = 0, nerr = 0;
   bit          rdy_rand = 1'b0;

   aq_djpeg_pixout_if #(.OUT_W(OUT_W)) pif ();

   aq_djpeg_pixout #(.FIFO_DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .Mode(Mode),
      .InWidth(InWidth), .InHeight(InHeight), .px(pif.slave),
      .Overflow(Overflow), .DropCount(DropCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference model: slots of the current word, expected word queue, drop count.
   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic             eol;
      logic             last;
   } word_t;
   word_t       exp_q[$];
   logic [31:0] m_slots[$];
   int          m_drop, m_w, m_h;
   bit          m_mode;

   function automatic bit eff_mode(bit m);
`ifdef AQ_DJPEG_PIXOUT_RGB565_EN
      return m;
`else
      return 1'b0 & m;
`endif
   endfunction

   function automatic void model_pix(int x, int y, logic [7:0] r, logic [7:0] g, logic [7:0] b);
      word_t w;
      int ppw, sw;
      ppw = m_mode ? OUT_W / 16 : OUT_W / 32;
      sw  = m_mode ? 16 : 32;
      if (x >= m_w || y >= m_h) begin
         if (m_drop < 65535) m_drop++;
         return;
      end
      if (m_mode) m_slots.push_back({16'h0, r[7:3], g[7:2], b[7:3]});
      else        m_slots.push_back({8'h00, r, g, b});
      if (m_slots.size() == ppw || x == m_w - 1) begin
         w.data = '0;
         foreach (m_slots[i]) w.data = w.data | (OUT_W'(m_slots[i]) << (i * sw));
         w.eol  = (x == m_w - 1);
         w.last = w.eol && (y == m_h - 1);
         exp_q.push_back(w);
         m_slots.delete();
      end
   endfunction

   // Scoreboard: every handshake must match the next modelled word.
   always @(negedge clk) begin : mon
      word_t e;
      if (!rst && pif.OutValid && pif.OutReady) begin
         if (exp_q.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL sb_extra: unexpected word %h", pif.OutData);
         end else begin
            e = exp_q.pop_front();
            chk("sb_data", 64'(pif.OutData), 64'(e.data));
            chk("sb_eol",  64'(pif.OutEol),  64'(e.eol));
            chk("sb_last", 64'(pif.OutLast), 64'(e.last));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rdy_rand) pif.OutReady = ($urandom_range(0, 3) != 0);
   endtask

   task automatic do_init(int w, int h, bit mode);
      ProcessInit = 1'b1;
      InWidth     = 16'(w);
      InHeight    = 16'(h);
      Mode        = mode;
      tick();
      exp_q.delete();
      m_slots.delete();
      m_drop = 0; m_w = w; m_h = h; m_mode = eff_mode(mode);
      ProcessInit = 1'b0;
      tick();
   endtask

   task automatic send_pix(int x, int y, logic [7:0] r, logic [7:0] g, logic [7:0] b, bit wait_rdy);
      int guard = 0;
      while (wait_rdy && !pif.InReady && guard < 500) begin
         tick();
         guard++;
      end
      if (guard >= 500) begin
         nvec++; nerr++;
         $display("FAIL rdy_timeout: InReady stayed 0, expected 1");
      end
      pif.InEnable = 1'b1;
      pif.InPixelX = 16'(x);
      pif.InPixelY = 16'(y);
      pif.InR = r; pif.InG = g; pif.InB = b;
      model_pix(x, y, r, g, b);
      tick();
      pif.InEnable = 1'b0;
   endtask

   task automatic drain(string nm);
      int g = 0;
      while (exp_q.size() != 0 && g < 400) begin
         tick();
         g++;
      end
      chk({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic run_frame(int w, int h, bit mode, bit gaps, bit rnd);
      do_init(w, h, mode);
      pif.OutReady = 1'b1;
      rdy_rand     = rnd;
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            if (gaps && $urandom_range(0, 3) == 0) tick();
            if (gaps && $urandom_range(0, 7) == 0)
               send_pix(w + $urandom_range(0, 3), y, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            if (gaps && $urandom_range(0, 9) == 0)
               send_pix(x, h + $urandom_range(0, 2), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            send_pix(x, y, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
         end
      drain("frame");
      rdy_rand     = 1'b0;
      pif.OutReady = 1'b1;
      repeat (3) tick();
      chk("frame_valid_end", 64'(pif.OutValid), 64'd0);
      chk("frame_drop",      64'(DropCount),    64'(m_drop));
      chk("frame_ovf",       64'(Overflow),     64'd0);
   endtask

   task automatic chk_reset_vals(string nm);
      chk({nm, "_valid"}, 64'(pif.OutValid), 64'd0);
      chk({nm, "_data"},  64'(pif.OutData),  64'd0);
      chk({nm, "_eol"},   64'(pif.OutEol),   64'd0);
      chk({nm, "_last"},  64'(pif.OutLast),  64'd0);
      chk({nm, "_ovf"},   64'(Overflow),     64'd0);
      chk({nm, "_drop"},  64'(DropCount),    64'd0);
      chk({nm, "_rdy"},   64'(pif.InReady),  64'd0);
   endtask

   typedef struct {
      int          w, h;
      bit          mode;
      int          x, y;
      logic [7:0]  r, g, b;
      bit          vld;
      logic [63:0] data;
      bit          eol, last;
      int          drop;
   } vec_t;
   vec_t tbl[9];

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      tbl[0] = '{1, 1, 1'b0, 0, 0, 8'h12, 8'h34, 8'h56, 1'b1, 64'h0000_0000_0012_3456, 1'b1, 1'b1, 0};
      tbl[1] = '{1, 1, 1'b0, 1, 0, 8'h12, 8'h34, 8'h56, 1'b0, 64'h0, 1'b0, 1'b0, 1};
      tbl[2] = '{1, 1, 1'b0, 0, 1, 8'h12, 8'h34, 8'h56, 1'b0, 64'h0, 1'b0, 1'b0, 1};
      tbl[3] = '{2, 1, 1'b0, 1, 0, 8'hFF, 8'h80, 8'h01, 1'b1, 64'h0000_0000_00FF_8001, 1'b1, 1'b1, 0};
      tbl[4] = '{2, 2, 1'b0, 1, 0, 8'hAA, 8'hBB, 8'hCC, 1'b1, 64'h0000_0000_00AA_BBCC, 1'b1, 1'b0, 0};
      tbl[5] = '{3, 1, 1'b0, 0, 0, 8'h11, 8'h22, 8'h33, 1'b0, 64'h0, 1'b0, 1'b0, 0};
`ifdef AQ_DJPEG_PIXOUT_RGB565_EN
      tbl[6] = '{1, 1, 1'b1, 0, 0, 8'h12, 8'h34, 8'h56, 1'b1, 64'h0000_0000_0000_11AA, 1'b1, 1'b1, 0};
`else
      tbl[6] = '{1, 1, 1'b1, 0, 0, 8'h12, 8'h34, 8'h56, 1'b1, 64'h0000_0000_0012_3456, 1'b1, 1'b1, 0};
`endif
      tbl[7] = '{2, 2, 1'b0, 0, 1, 8'h01, 8'h02, 8'h03, 1'b0, 64'h0, 1'b0, 1'b0, 0};
      tbl[8] = '{5, 5, 1'b0, 5, 0, 8'h01, 8'h02, 8'h03, 1'b0, 64'h0, 1'b0, 1'b0, 1};

      rst = 1'b1; ProcessInit = 1'b1; Mode = 1'b0; InWidth = '0; InHeight = '0;
      pif.InEnable = 1'b0; pif.InPixelX = '0; pif.InPixelY = '0;
      pif.InR = '0; pif.InG = '0; pif.InB = '0; pif.OutReady = 1'b0;
      #2;
      chk_reset_vals("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tick();
      chk("idle_rdy", 64'(pif.InReady), 64'd0);

      // Single-pixel frames: latency, packing, flags, cropping.
      foreach (tbl[i]) begin
         do_init(tbl[i].w, tbl[i].h, tbl[i].mode);
         send_pix(tbl[i].x, tbl[i].y, tbl[i].r, tbl[i].g, tbl[i].b, 1'b0);
         chk($sformatf("v%0d_early", i), 64'(pif.OutValid), 64'd0);
         tick(); tick();
         chk($sformatf("v%0d_valid", i), 64'(pif.OutValid), 64'(tbl[i].vld));
         chk($sformatf("v%0d_data", i),  64'(pif.OutData),  tbl[i].data);
         chk($sformatf("v%0d_eol", i),   64'(pif.OutEol),   64'(tbl[i].eol));
         chk($sformatf("v%0d_last", i),  64'(pif.OutLast),  64'(tbl[i].last));
         chk($sformatf("v%0d_drop", i),  64'(DropCount),    64'(tbl[i].drop));
      end

      // 4x2 frame streamed with OutReady held high.
      run_frame(4, 2, 1'b0, 1'b0, 1'b0);

      // Width 3, X=0..4 on the first of two rows: two pixels cropped.
      do_init(3, 2, 1'b1);
      pif.OutReady = 1'b1;
      for (int x = 0; x < 5; x++) send_pix(x, 0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
      drain("crop");
      chk("crop_drop", 64'(DropCount), 64'd2);

      // Backpressure on a 4-deep FIFO, then a single one-cycle transfer.
      do_init(2, 8, 1'b0);
      pif.OutReady = 1'b0;
      for (int i = 0; i < 4; i++) send_pix(i % 2, i / 2, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      tick(); tick();
      chk("bp_rdy2", 64'(pif.InReady), 64'd1);
      send_pix(0, 2, 8'h5A, 8'hA5, 8'h3C, 1'b0);
      send_pix(1, 2, 8'hC3, 8'h0F, 8'hF0, 1'b0);
      tick(); tick();
      chk("bp_rdy3", 64'(pif.InReady), 64'd0);
      repeat (3) begin
         chk("bp_hold", 64'(pif.OutData), 64'(exp_q[0].data));
         tick();
      end
      pif.OutReady = 1'b1;
      tick();
      pif.OutReady = 1'b0;
      tick();
      chk("bp_xfers", 64'(exp_q.size()), 64'd2);
      chk("bp_next",  64'(pif.OutData),  64'(exp_q[0].data));
      chk("bp_rdy",   64'(pif.InReady),  64'd1);

      // ProcessInit with three words queued and one pixel cropped.
      send_pix(5, 3, 8'h01, 8'h02, 8'h03, 1'b0);
      send_pix(0, 3, 8'h11, 8'h22, 8'h33, 1'b0);
      send_pix(1, 3, 8'h44, 8'h55, 8'h66, 1'b0);
      tick(); tick();
      chk("pi_pre_drop",  64'(DropCount),    64'd1);
      chk("pi_pre_valid", 64'(pif.OutValid), 64'd1);
      ProcessInit = 1'b1;
      tick();
      chk("pi_valid", 64'(pif.OutValid), 64'd0);
      chk("pi_drop",  64'(DropCount),    64'd0);
      chk("pi_rdy",   64'(pif.InReady),  64'd0);
      ProcessInit = 1'b0;
      run_frame(3, 2, 1'b1, 1'b1, 1'b1);

      // Five words into a 4-deep FIFO with no reader.
      do_init(2, 10, 1'b0);
      pif.OutReady = 1'b0;
      for (int i = 0; i < 10; i++) send_pix(i % 2, i / 2, 8'(i), 8'(i + 1), 8'(i + 2), 1'b0);
      repeat (3) tick();
      chk("ovf_set",   64'(Overflow),      64'd1);
      chk("ovf_head",  64'(pif.OutData),   64'(exp_q[0].data));
      repeat (3) tick();
      chk("ovf_stick", 64'(Overflow),      64'd1);
      do_init(2, 2, 1'b0);
      chk("ovf_clear", 64'(Overflow),      64'd0);

      // Asynchronous reset in the middle of a cycle with words queued.
      do_init(2, 6, 1'b0);
      pif.OutReady = 1'b0;
      for (int i = 0; i < 6; i++) send_pix(i % 2, i / 2, 8'hA0, 8'(i), 8'h0B, 1'b0);
      send_pix(9, 0, 8'h00, 8'h00, 8'h00, 1'b0);
      tick();
      chk("ar_pre_valid", 64'(pif.OutValid), 64'd1);
      #3 rst = 1'b1;
      #1;
      chk_reset_vals("areset");
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();

      // Randomized frames with random backpressure.
      for (int f = 0; f < 16; f++)
         run_frame($urandom_range(1, 6), $urandom_range(1, 4), 1'($urandom), 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/aq_djpeg_pixout.md
AQ_DJPEG_PIXOUT -- requirements
Module: aq_djpeg_pixout

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: output word FIFO entries; power of two, 4..256.
REQ-002 Parameter OUT_W, default 32: output word width; legal values 32 or 64.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port ProcessInit, input, 1: high = decoder idle; holds the block in IDLE and clears the frame state.
REQ-006 Port Mode, input, 1: 0 = RGB888, 1 = RGB565.
REQ-007 Ports InWidth, InHeight, input, 16 each: image size.
REQ-008 Ports InEnable, input, 1; InPixelX, InPixelY, input, 16 each; InR, InG, InB, input, 8 each: pixel from color conversion.
REQ-009 Port InReady, output, 1: pixel may be presented.
REQ-010 Ports OutValid, output, 1; OutReady, input, 1; OutData, output, OUT_W; OutEol, output, 1; OutLast, output, 1: packed word stream.
REQ-011 Ports Overflow, output, 1: sticky; DropCount, output, 16: cropped-pixel count.

Function
REQ-012 FSM states: IDLE, RUN, DONE.
- IDLE->RUN: ProcessInit low.
- RUN->DONE: last frame pixel packed.
- Any state->IDLE: ProcessInit high, cleared on the next edge.
REQ-013 Mode is latched on the IDLE->RUN edge and is constant for the frame.
REQ-014 Cropping: an accepted pixel with X>=InWidth or Y>=InHeight is discarded; DropCount increments, saturating at 16'hFFFF.
REQ-015 Pixel slot size:
- RGB888: 32-bit slot {8'h00,R,G,B}.
- RGB565: 16-bit slot {R[7:3],G[7:2],B[7:3]}.
- Pixels per word PPW = OUT_W/32 (RGB888) or OUT_W/16 (RGB565).
REQ-016 Packing is little-endian: the first pixel occupies OutData[slot-1:0].
REQ-017 Word completion:
- A word is complete at PPW pixels, or at a pixel with X==InWidth-1.
- Unused slots are zero.
- Row end sets OutEol.
- X==InWidth-1 with Y==InHeight-1 also sets OutLast.
REQ-018 A completed word is written to the FIFO on the clock edge after the completing pixel is accepted.
REQ-019 OutValid is asserted no earlier than 2 cycles after the completing pixel's InEnable cycle.
REQ-020 Pixels are accepted only in RUN with InEnable high; in IDLE and DONE they are ignored and not counted.
REQ-021 Output handshake:
- A word transfers when OutValid and OutReady are both high.
- OutData, OutEol and OutLast are held stable while OutValid is high and OutReady is low.
- OutValid is never deasserted without a transfer, except on ProcessInit.
REQ-022 InReady is registered, and is high when the FIFO free entries >= 2 counting a same-cycle pop.
REQ-023 FIFO boundaries:
- Simultaneous push and pop on a full FIFO is legal.
- Pointers wrap modulo FIFO_DEPTH.
- Empty FIFO: OutValid low.
REQ-024 Overflow:
- InEnable while InReady is low and the pixel would complete a word into a full FIFO: the word is discarded and Overflow is set.
- Overflow stays set until ProcessInit or rst.
REQ-025 ProcessInit high mid-frame: within one cycle it flushes the FIFO and the packing accumulator and clears OutValid and DropCount; Overflow is cleared.

Reset
REQ-026 rst asserted:
- State = IDLE; FIFO pointers and pack index = 0.
- OutValid, OutEol, OutLast, Overflow = 0; DropCount = 0; OutData = 0.
- InReady = 0 in IDLE.
REQ-027 rst is deasserted synchronously externally; after reset the block behaves identically to after ProcessInit.

Configuration
REQ-028 Macro AQ_DJPEG_PIXOUT_RGB565_EN defined: Mode is honoured per REQ-013 and REQ-015.
REQ-029 Macro undefined: the RGB565 logic is absent, Mode is ignored, and packing is always RGB888.

Verification
REQ-030 OUT_W=32, RGB888, 4x2 image, OutReady=1 -> 8 words {00,R,G,B}; OutEol on words 4 and 8; OutLast on word 8 only.
REQ-031 OUT_W=64, RGB565, width 5, row of pixels R=G=B=8'hFF -> words 64'hFFFF_FFFF_FFFF_FFFF, then 64'h0000_0000_0000_FFFF with OutEol.
REQ-032 Width 3, pixels at X=0..4 -> 1 word, DropCount=2.
REQ-033 FIFO_DEPTH=4, OutReady=0 -> InReady falls after 3 words; OutReady=1 for one cycle -> exactly one transfer with data unchanged beforehand.
REQ-034 ProcessInit pulsed with 3 words queued -> next cycle OutValid=0, DropCount=0; a new frame starts cleanly.
REQ-035 rst asserted mid-frame asynchronously -> all outputs take REQ-026 values before the next clk edge.
